// File: rtl/hazard_fwd_ctrl_if.sv
// Pipeline-side view of the forwarding/hazard controller: ID/EX/MEM/WB operand info in,
// bypass selects, stall/bubble controls and the stall counter out.
interface hazard_fwd_ctrl_if #(
  parameter int RA_W    = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic                    flush;
  logic [NUM_SRC-1:0]      id_src_valid;
  logic [NUM_SRC*RA_W-1:0] id_src_addr;
  logic [NUM_SRC*RA_W-1:0] ex_src_addr;
  logic                    ex_valid;
  logic                    ex_wr_en;
  logic                    ex_is_load;
  logic                    ex_is_mdu;
  logic [RA_W-1:0]         ex_dst_addr;
  logic                    mem_wr_en;
  logic                    mem_is_load;
  logic [RA_W-1:0]         mem_dst_addr;
  logic                    wb_wr_en;
  logic [RA_W-1:0]         wb_dst_addr;

  logic [NUM_SRC*2-1:0]    fwd_sel;
  logic                    stall_front;
  logic                    stall_ex;
  logic                    bubble_ex;
  logic                    bubble_mem;
  logic                    mdu_busy;
  logic [CNT_W-1:0]        stall_cycles;

  modport master (
    output flush, id_src_valid, id_src_addr, ex_src_addr, ex_valid, ex_wr_en,
           ex_is_load, ex_is_mdu, ex_dst_addr, mem_wr_en, mem_is_load, mem_dst_addr,
           wb_wr_en, wb_dst_addr,
    input  fwd_sel, stall_front, stall_ex, bubble_ex, bubble_mem, mdu_busy, stall_cycles
  );

  modport slave (
    input  flush, id_src_valid, id_src_addr, ex_src_addr, ex_valid, ex_wr_en,
           ex_is_load, ex_is_mdu, ex_dst_addr, mem_wr_en, mem_is_load, mem_dst_addr,
           wb_wr_en, wb_dst_addr,
    output fwd_sel, stall_front, stall_ex, bubble_ex, bubble_mem, mdu_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Forwarding and hazard controller for the pipelined MIPS core: per-source bypass selects,
// load-use bubbles, multi-cycle MDU stalls and a saturating stall-cycle counter.
module hazard_fwd_ctrl #(
  parameter int RA_W    = 5,
  parameter int NUM_SRC = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  hazard_fwd_ctrl_if.slave bus
);
  localparam int MC_W = $clog2(MDU_LAT);

  typedef enum logic {
    IDLE     = 1'b0,
    MDU_BUSY = 1'b1
  } state_t;

  state_t               state;
  logic [MC_W-1:0]      cnt;
  logic [CNT_W-1:0]     stall_cnt;
  logic [NUM_SRC*2-1:0] fwd_sel_c;
  logic                 lu_src;
  logic                 lu_hit;
  logic                 mdu_hit;
  logic                 mdu_stall;
  logic                 lu_stall;
  logic                 stall_front_c;

  // EX/MEM beats MEM/WB because it holds the younger write to the same register.
  always_comb begin
    fwd_sel_c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.mem_wr_en && (bus.mem_dst_addr != '0) &&
          (bus.mem_dst_addr == bus.ex_src_addr[i*RA_W +: RA_W]))
        fwd_sel_c[2*i +: 2] = bus.mem_is_load ? 2'b10 : 2'b01;
      else if (bus.wb_wr_en && (bus.wb_dst_addr != '0) &&
               (bus.wb_dst_addr == bus.ex_src_addr[i*RA_W +: RA_W]))
        fwd_sel_c[2*i +: 2] = 2'b11;
    end
  end

  always_comb begin
    lu_src = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      lu_src = lu_src | (bus.id_src_valid[i] &&
                         (bus.id_src_addr[i*RA_W +: RA_W] == bus.ex_dst_addr));
  end

  assign lu_hit  = bus.ex_valid & bus.ex_is_load & bus.ex_wr_en &
                   (bus.ex_dst_addr != '0) & lu_src;
  assign mdu_hit = bus.ex_valid & bus.ex_is_mdu;

  // Stall decisions are Mealy so the pipe reacts in the same cycle the hazard is seen.
  always_comb begin
    mdu_stall = 1'b0;
    lu_stall  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.flush) begin
          if (mdu_hit)     mdu_stall = 1'b1;
          else if (lu_hit) lu_stall  = 1'b1;
        end
      end
      MDU_BUSY: begin
        if (!bus.flush && (cnt != '0)) mdu_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_front_c = mdu_stall | lu_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      stall_cnt <= '0;
    end else begin
      if (stall_front_c && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      case (state)
        IDLE: begin
          if (!bus.flush && mdu_hit) begin
            state <= MDU_BUSY;
            cnt   <= MC_W'(MDU_LAT - 2);
          end
        end
        MDU_BUSY: begin
          if (bus.flush) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - MC_W'(1);
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Reset forces every output low, including the purely combinational bypass selects.
  assign bus.fwd_sel      = rst ? '0 : fwd_sel_c;
  assign bus.stall_front  = ~rst & stall_front_c;
  assign bus.stall_ex     = ~rst & mdu_stall;
  assign bus.bubble_ex    = ~rst & lu_stall;
  assign bus.bubble_mem   = ~rst & mdu_stall;
  assign bus.mdu_busy     = ~rst & (state == MDU_BUSY);
  assign bus.stall_cycles = rst ? '0 : stall_cnt;
endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: a per-cycle behavioural model compared on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_hazard_fwd_ctrl;
  localparam int RA_W    = 5;
  localparam int NUM_SRC = 2;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic [1:0] id_v;
    logic [4:0] id0;
    logic [4:0] id1;
    logic [4:0] ex0;
    logic [4:0] ex1;
    logic       ex_valid;
    logic       ex_wr;
    logic       ex_ld;
    logic       ex_mdu;
    logic [4:0] ex_dst;
    logic       mem_wr;
    logic       mem_ld;
    logic [4:0] mem_dst;
    logic       wb_wr;
    logic [4:0] wb_dst;
  } stim_t;

  logic  clk = 1'b0;
  logic  rst;
  int    total_cnt = 0;
  int    bad_cnt   = 0;
  bit    check_en  = 1'b0;
  stim_t s;

  int m_age   = 0;
  int m_count = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl_if #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

  hazard_fwd_ctrl #(.RA_W(RA_W), .NUM_SRC(NUM_SRC), .MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive a full input vector just after the rising edge, then wait for the sample point.
  task automatic applyStimulus(input stim_t v);
    @(posedge clk);
    #1;
    rst              = v.rst;
    bus.flush        = v.flush;
    bus.id_src_valid = v.id_v;
    bus.id_src_addr  = {v.id1, v.id0};
    bus.ex_src_addr  = {v.ex1, v.ex0};
    bus.ex_valid     = v.ex_valid;
    bus.ex_wr_en     = v.ex_wr;
    bus.ex_is_load   = v.ex_ld;
    bus.ex_is_mdu    = v.ex_mdu;
    bus.ex_dst_addr  = v.ex_dst;
    bus.mem_wr_en    = v.mem_wr;
    bus.mem_is_load  = v.mem_ld;
    bus.mem_dst_addr = v.mem_dst;
    bus.wb_wr_en     = v.wb_wr;
    bus.wb_dst_addr  = v.wb_dst;
    @(negedge clk);
  endtask

  // Model: m_age counts how many cycles the current MDU op has already spent in EX (0 = none).
  function automatic void model_stalls(output logic smdu, output logic slu);
    bit mdu_hit, lu_hit;
    mdu_hit = bus.ex_valid && bus.ex_is_mdu;
    lu_hit  = 1'b0;
    if (bus.ex_valid && bus.ex_is_load && bus.ex_wr_en && int'(bus.ex_dst_addr) != 0)
      for (int i = 0; i < NUM_SRC; i++)
        if (bus.id_src_valid[i] && bus.id_src_addr[i*RA_W +: RA_W] == bus.ex_dst_addr)
          lu_hit = 1'b1;
    smdu = 1'b0;
    slu  = 1'b0;
    if (!bus.flush) begin
      if (m_age == 0) begin
        smdu = mdu_hit;
        slu  = !mdu_hit && lu_hit;
      end else begin
        smdu = (m_age < MDU_LAT - 1);
      end
    end
  endfunction

  function automatic logic [3:0] model_fwd();
    logic [3:0] f;
    int src;
    f = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src = int'(bus.ex_src_addr[i*RA_W +: RA_W]);
      if (bus.mem_wr_en && int'(bus.mem_dst_addr) != 0 && int'(bus.mem_dst_addr) == src)
        f[2*i +: 2] = bus.mem_is_load ? 2'd2 : 2'd1;
      else if (bus.wb_wr_en && int'(bus.wb_dst_addr) != 0 && int'(bus.wb_dst_addr) == src)
        f[2*i +: 2] = 2'd3;
    end
    return f;
  endfunction

  always @(posedge clk) begin
    logic smdu, slu;
    model_stalls(smdu, slu);
    if (rst) begin
      m_age   = 0;
      m_count = 0;
    end else begin
      if ((smdu || slu) && m_count < CNT_MAX) m_count = m_count + 1;
      if (bus.flush)                 m_age = 0;
      else if (m_age == 0)           m_age = (bus.ex_valid && bus.ex_is_mdu) ? 1 : 0;
      else if (m_age == MDU_LAT - 1) m_age = 0;
      else                           m_age = m_age + 1;
    end
  end

  always @(negedge clk) begin
    logic smdu, slu;
    if (check_en) begin
      model_stalls(smdu, slu);
      if (rst) begin
        checkOutput("cyc_fwd_sel", bus.fwd_sel, 0);
        checkOutput("cyc_stall_front", bus.stall_front, 0);
        checkOutput("cyc_stall_ex", bus.stall_ex, 0);
        checkOutput("cyc_bubble_ex", bus.bubble_ex, 0);
        checkOutput("cyc_bubble_mem", bus.bubble_mem, 0);
        checkOutput("cyc_mdu_busy", bus.mdu_busy, 0);
        checkOutput("cyc_stall_cycles", bus.stall_cycles, 0);
      end else begin
        checkOutput("cyc_fwd_sel", bus.fwd_sel, model_fwd());
        checkOutput("cyc_stall_front", bus.stall_front, smdu | slu);
        checkOutput("cyc_stall_ex", bus.stall_ex, smdu);
        checkOutput("cyc_bubble_ex", bus.bubble_ex, slu);
        checkOutput("cyc_bubble_mem", bus.bubble_mem, smdu);
        checkOutput("cyc_mdu_busy", bus.mdu_busy, m_age != 0);
        checkOutput("cyc_stall_cycles", bus.stall_cycles, m_count);
      end
    end
  end

  initial begin
    logic [3:0] exp_sf;
    logic [3:0] exp_busy;
    exp_sf   = 4'b0111;
    exp_busy = 4'b1110;

    rst = 1'b1;
    s = '0;
    s.rst = 1'b1;
    applyStimulus(s);
    check_en = 1'b1;
    s.mem_wr = 1'b1; s.mem_dst = 5'd5; s.ex0 = 5'd5;
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("rst_fwd_sel", bus.fwd_sel, 0);
    checkOutput("rst_stall_front", bus.stall_front, 0);
    checkOutput("rst_stall_cycles", bus.stall_cycles, 0);

    s = '0; s.mem_wr = 1'b1; s.mem_dst = 5'd5; s.ex0 = 5'd5; s.ex1 = 5'd5;
    applyStimulus(s);
    checkOutput("alu_chain_fwd", bus.fwd_sel, 4'b0101);

    s = '0; s.mem_wr = 1'b1; s.mem_ld = 1'b1; s.mem_dst = 5'd7;
    s.wb_wr = 1'b1; s.wb_dst = 5'd7; s.ex0 = 5'd2; s.ex1 = 5'd7;
    applyStimulus(s);
    checkOutput("prio_load_fwd", bus.fwd_sel, 4'b1000);

    s.mem_dst = 5'd0; s.wb_dst = 5'd0; s.ex1 = 5'd0;
    applyStimulus(s);
    checkOutput("prio_r0_fwd", bus.fwd_sel, 4'b0000);

    s = '0; s.wb_wr = 1'b1; s.wb_dst = 5'd9; s.ex0 = 5'd9;
    applyStimulus(s);
    checkOutput("wb_only_fwd", bus.fwd_sel, 4'b0011);

    s = '0; s.ex_valid = 1'b1; s.ex_wr = 1'b1; s.ex_ld = 1'b1; s.ex_dst = 5'd3;
    s.id_v = 2'b01; s.id0 = 5'd3;
    applyStimulus(s);
    checkOutput("lu_stall_front", bus.stall_front, 1);
    checkOutput("lu_bubble_ex", bus.bubble_ex, 1);
    checkOutput("lu_stall_ex", bus.stall_ex, 0);
    applyStimulus('0);
    checkOutput("lu_released", bus.stall_front, 0);
    checkOutput("lu_count", bus.stall_cycles, 1);

    s.id_v = 2'b00;
    applyStimulus(s);
    checkOutput("lu_invalid_src", bus.stall_front, 0);

    s.id_v = 2'b10; s.id0 = 5'd0; s.id1 = 5'd3;
    applyStimulus(s);
    checkOutput("lu_src1_stall", bus.bubble_ex, 1);
    applyStimulus('0);

    s = '0; s.ex_valid = 1'b1; s.ex_wr = 1'b1; s.ex_ld = 1'b1; s.ex_dst = 5'd0;
    s.id_v = 2'b01; s.id0 = 5'd0;
    applyStimulus(s);
    checkOutput("lu_r0_nostall", bus.stall_front, 0);
    checkOutput("lu_count2", bus.stall_cycles, 2);

    s = '0; s.ex_valid = 1'b1; s.ex_mdu = 1'b1;
    for (int c = 0; c < MDU_LAT; c++) begin
      applyStimulus(s);
      checkOutput("mdu_stall_front", bus.stall_front, exp_sf[c]);
      checkOutput("mdu_bubble_mem", bus.bubble_mem, exp_sf[c]);
      checkOutput("mdu_busy", bus.mdu_busy, exp_busy[c]);
    end
    applyStimulus('0);
    checkOutput("mdu_released", bus.mdu_busy, 0);
    checkOutput("mdu_count", bus.stall_cycles, 5);

    applyStimulus(s);
    s.flush = 1'b1;
    applyStimulus(s);
    checkOutput("flush_stall_front", bus.stall_front, 0);
    checkOutput("flush_stall_ex", bus.stall_ex, 0);
    checkOutput("flush_busy_that_cycle", bus.mdu_busy, 1);
    applyStimulus('0);
    checkOutput("flush_idle_next", bus.mdu_busy, 0);
    checkOutput("flush_count", bus.stall_cycles, 6);

    s.flush = 1'b0;
    applyStimulus(s);
    s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("rst_mid_stall", bus.stall_front, 0);
    checkOutput("rst_mid_busy", bus.mdu_busy, 0);
    applyStimulus('0);
    checkOutput("rst_idle_next", bus.mdu_busy, 0);
    checkOutput("rst_count_cleared", bus.stall_cycles, 0);

    s = '0; s.ex_valid = 1'b1; s.ex_mdu = 1'b1;
    for (int c = 0; c < MDU_LAT; c++) applyStimulus(s);
    s = '0; s.ex_valid = 1'b1; s.ex_wr = 1'b1; s.ex_ld = 1'b1; s.ex_dst = 5'd3;
    s.id_v = 2'b01; s.id0 = 5'd3;
    applyStimulus(s);
    checkOutput("lu_after_mdu", bus.bubble_ex, 1);
    checkOutput("lu_after_mdu_count", bus.stall_cycles, 3);

    s.rst = 1'b1;
    applyStimulus(s);
    s.rst = 1'b0;
    for (int c = 0; c < 20; c++) applyStimulus(s);
    applyStimulus('0);
    checkOutput("sat_count", bus.stall_cycles, 15);

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
